sync_fifo: RTL

- Single-clock, parametrised FIFO; next generation of the team's dual-clock FIFO, for same-domain buffering where CDC synchronisers are pure latency cost.
- Adds over the dual-clock block:
  - selectable read mode (registered or show-ahead/FWFT);
  - programmable almost-full/almost-empty thresholds;
  - exact fill-level output;
  - optional sticky overflow/underflow error flags.
- Sits between streaming producers/consumers inside one clock domain.

---
 rtl/fifo_pkg.sv | 35 +++
 rtl/sync_fifo_mem.sv | 56 +++++
 rtl/sync_fifo.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the FIFO family (single- and dual-clock).
//   - fifo_addr_width(): address width for a given entry count.
//   - FIFO_MODE_REG / FIFO_MODE_SHOWAHEAD: read-mode selector values.
//   - FIFO_CHECK_* macros: elaboration-time parameter checks, expanded as
//     generate blocks inside the module body that uses them.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_CHECK_WIDTH(W) \
  if ((W) < 1) begin : g_chk_width \
    $error("FIFO data width must be at least 1"); \
  end

`define FIFO_CHECK_DEPTH(DEPTH) \
  if (((DEPTH) < 4) || ((((DEPTH) - 1) & (DEPTH)) != 0)) begin : g_chk_depth \
    $error("FIFO depth must be a power of two and at least 4"); \
  end

`define FIFO_CHECK_RANGE(LABEL, VAL, LO, HI) \
  if (((VAL) < (LO)) || ((VAL) > (HI))) begin : LABEL \
    $error("FIFO parameter out of range"); \
  end

package fifo_pkg;

  localparam int FIFO_MODE_REG       = 0;
  localparam int FIFO_MODE_SHOWAHEAD = 1;

  function automatic int fifo_addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`endif

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: register-array storage for the FIFO family.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (clears the registered read data only)
//   wr_en   : write strobe, writes wr_data to wr_addr
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read strobe (registered read mode only)
//   rd_addr : read address
//   rd_data : read data; registered on rd_en (FIFO_MODE_REG) or
//             combinational from rd_addr (FIFO_MODE_SHOWAHEAD)
// The array contents themselves are never reset.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int READ_MODE  = FIFO_MODE_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  if (READ_MODE == FIFO_MODE_SHOWAHEAD) begin : g_comb_rd
    // Read strobe and reset have no effect on an asynchronous read port.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = rst ^ rd_en;
    assign rd_data = mem_q[rd_addr];
  end else begin : g_reg_rd
    logic [DATA_WIDTH-1:0] rd_data_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q <= '0;
      end else if (rd_en) begin
        rd_data_q <= mem_q[rd_addr];
      end
    end
    assign rd_data = rd_data_q;
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock parametrised FIFO with registered or show-ahead
// read, programmable almost-full/almost-empty thresholds, exact fill level
// and optional sticky error flags.
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   wr_en, wr_data    : write request and data (ignored while full)
//   full, afull       : no free entry / level >= AFULL_TH
//   rd_en             : read request (pop in show-ahead mode, ignored while empty)
//   rd_data, rd_valid : read data and its qualifier
//   empty, aempty     : no stored entry / level <= AEMPTY_TH
//   level             : entries stored, 0..FIFO_DEPTH
//   err_clr           : clears the sticky error flags
//   overflow          : sticky, write attempted while full
//   underflow         : sticky, read attempted while empty
// Build option: define SYNC_FIFO_ERR_EN to enable overflow/underflow; when
// undefined both are tied low and err_clr is ignored. Ports are the same.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 16,
  parameter  int AFULL_TH   = FIFO_DEPTH - 2,
  parameter  int AEMPTY_TH  = 2,
  parameter  int SHOWAHEAD  = FIFO_MODE_REG,
  localparam int ADDR_WIDTH = fifo_addr_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  afull,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   level,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  `FIFO_CHECK_WIDTH(DATA_WIDTH)
  `FIFO_CHECK_DEPTH(FIFO_DEPTH)
  `FIFO_CHECK_RANGE(g_chk_afull_th, AFULL_TH, 1, FIFO_DEPTH)
  `FIFO_CHECK_RANGE(g_chk_aempty_th, AEMPTY_TH, 0, FIFO_DEPTH - 1)
  `FIFO_CHECK_RANGE(g_chk_showahead, SHOWAHEAD, FIFO_MODE_REG, FIFO_MODE_SHOWAHEAD)

  localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL  = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH + 1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_TH);

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  wr_vld, rd_vld;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Only qualified handshakes move pointers or touch the memory. The
  // qualifiers use registered flags, so wr_en never reaches full and rd_en
  // never reaches empty combinationally.
  assign wr_vld = wr_en & ~full_q;
  assign rd_vld = rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_vld) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_vld) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    level_d = level_q + {{ADDR_WIDTH{1'b0}}, wr_vld} - {{ADDR_WIDTH{1'b0}}, rd_vld};
  end

  // Flags are registered from the next-state level so they are exact in
  // the cycle after each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == DEPTH_LVL);
      empty_q  <= (level_d == '0);
      afull_q  <= (level_d >= AFULL_LVL);
      aempty_q <= (level_d <= AEMPTY_LVL);
    end
  end

  assign full   = full_q;
  assign empty  = empty_q;
  assign afull  = afull_q;
  assign aempty = aempty_q;
  assign level  = level_q;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .READ_MODE  (SHOWAHEAD)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_vld),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_vld),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (mem_rd_data)
  );

  if (SHOWAHEAD == FIFO_MODE_SHOWAHEAD) begin : g_fwft
    // Head word is visible whenever something is stored; the memory is not
    // reset, so its output is masked to zero while empty.
    assign rd_valid = ~empty_q;
    assign rd_data  = empty_q ? '0 : mem_rd_data;
  end else begin : g_regrd
    logic rd_valid_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_vld;
      end
    end
    assign rd_valid = rd_valid_q;
    assign rd_data  = mem_rd_data;
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en & full_q) begin
        overflow_q <= 1'b1;
      end else if (err_clr) begin
        overflow_q <= 1'b0;
      end
      if (rd_en & empty_q) begin
        underflow_q <= 1'b1;
      end else if (err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
